// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write/status bundle between MMIO decode and the UART transmit FIFO
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          ovf;
  logic          tx;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, busy, ovf, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, busy, ovf, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 serializer that drives the board Tx pin
module uart_tx_fifo #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  uart_tx_fifo_if.slave io_bus
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_was_active;

  logic w_full, w_empty, w_push, w_pop, w_baud_done;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  // A write while full is dropped even if the serializer pops on the same edge.
  assign w_push      = io_bus.wr_en && !w_full;
  assign w_baud_done = (r_baud == BAUD_LAST);

  // Byte storage; contents need no reset because occupancy is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.wr_data;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (io_bus.wr_en && w_full) r_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Serializer state register; TX is registered so it trails the state by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_was_active <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_baud       <= w_baud_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_was_active <= (r_state != S_IDLE);
    end
  end

  // Serializer next state, bit timing, FIFO pop and next TX level.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // BUSY is held until the registered stop bit has actually left the pin.
  assign io_bus.full  = w_full;
  assign io_bus.empty = w_empty;
  assign io_bus.count = r_count;
  assign io_bus.ovf   = r_ovf;
  assign io_bus.tx    = r_tx;
  assign io_bus.busy  = (r_state != S_IDLE) || !w_empty || r_was_active;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame-level reference model
module tb_uart_tx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: queue of waiting bytes plus the position inside the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  bit         m_active;
  int         m_elapsed;
  logic [7:0] m_cur;
  bit         m_ovf;
  logic       m_tx;
  bit         m_line;

  // Line decoder sampling the middle of each bit.
  int         rx_t = -1;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];
  int         first_fall = -1;
  logic       ptx = 1'b1;

  typedef struct {
    logic       rst_n;
    logic       wr_en;
    logic [7:0] data;
    logic       tx;
    int         count;
    logic       empty;
    logic       full;
    logic       busy;
    logic       ovf;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_elapsed = 0; m_ovf = 0; m_tx = 1'b1; m_line = 0;
    rx_t = -1; ptx = 1'b1;
  endtask

  task automatic model_edge(input logic rst, input logic we, input logic [7:0] d);
    bit full_pre, pop;
    if (!rst) begin
      model_reset();
      return;
    end
    full_pre = (m_q.size() == DEPTH);
    m_line   = m_active;
    m_tx     = m_active ? frame_bit(m_cur, m_elapsed / CPB) : 1'b1;
    pop = 0;
    if (m_active) begin
      m_elapsed++;
      if (m_elapsed == FRAME) begin
        m_active = 0;
        pop = (m_q.size() > 0);
      end
    end else begin
      pop = (m_q.size() > 0);
    end
    if (pop) begin
      m_cur = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_active = 1;
      m_elapsed = 0;
    end
    if (we) begin
      if (full_pre) m_ovf = 1;
      else          m_q.push_back(d);
    end
  endtask

  task automatic check_model();
    check("tx",    bus.tx,    m_tx);
    check("count", bus.count, m_q.size());
    check("empty", bus.empty, m_q.size() == 0);
    check("full",  bus.full,  m_q.size() == DEPTH);
    check("busy",  bus.busy,  m_active || m_q.size() > 0 || m_line);
    check("ovf",   bus.ovf,   m_ovf);
  endtask

  task automatic decode();
    if (ptx === 1'b1 && bus.tx === 1'b0 && first_fall < 0) first_fall = cyc;
    ptx = bus.tx;
    if (rx_t < 0) begin
      if (bus.tx === 1'b0) rx_t = 0;
    end else begin
      rx_t++;
      for (int k = 1; k <= 8; k++)
        if (rx_t == k * CPB + CPB / 2) rx_sh[k-1] = bus.tx;
      if (rx_t == 9 * CPB + CPB / 2) begin
        check("stop_bit", bus.tx, 1'b1);
        rx_q.push_back(rx_sh);
        rx_t = -1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic [7:0] d);
    @(negedge clk);
    rst_n = rst; bus.wr_en = we; bus.wr_data = d;
    @(posedge clk);
    cyc++;
    model_edge(rst, we, d);
    #1;
    check_model();
    if (rst) decode();
  endtask

  task automatic drain(input string name, output int drop_cyc);
    int k;
    for (k = 0; k < 2000 && bus.busy !== 1'b0; k++) step(1'b1, 1'b0, 8'h00);
    if (bus.busy !== 1'b0) fail_now(name);
    drop_cyc = cyc;
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_nbytes"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], exp[i]);
  endtask

  initial begin
    int wr_c, drop_c, fall_c;
    bit found;
    logic [7:0] exp[$];

    rst_n = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'h00;
    model_reset();

    // Reset behaviour and single-byte latency, as explicit vectors.
    vecs[0] = '{1'b0, 1'b1, 8'h55, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hAA, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    wr_c = 0;
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].rst_n, vecs[i].wr_en, vecs[i].data);
      if (i == 2) wr_c = cyc;
      check("vec_tx",    bus.tx,    vecs[i].tx);
      check("vec_count", bus.count, vecs[i].count);
      check("vec_empty", bus.empty, vecs[i].empty);
      check("vec_full",  bus.full,  vecs[i].full);
      check("vec_busy",  bus.busy,  vecs[i].busy);
      check("vec_ovf",   bus.ovf,   vecs[i].ovf);
    end
    fall_c = first_fall;
    drain("t2_drain", drop_c);
    check("t2_fall_latency", fall_c - wr_c, 2);
    check("t2_busy_after_fall", drop_c - fall_c, FRAME);
    exp = '{8'hA5};
    check_rx("t2_rx", exp);

    // Burst of three: frames back-to-back.
    rx_q.delete(); first_fall = -1;
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    drain("t3_drain", drop_c);
    check("t3_span", drop_c - first_fall, 3 * FRAME);
    exp = '{8'h01, 8'h02, 8'h03};
    check_rx("t3_rx", exp);

    // Overflow: sixth write is dropped and OVF sticks.
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'h10 + 8'(i));
      if (i == 4) check("t4_full_after_5", bus.full, 1'b1);
    end
    check("t4_ovf_set", bus.ovf, 1'b1);
    drain("t4_drain", drop_c);
    check("t4_ovf_sticky", bus.ovf, 1'b1);
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_rx("t4_rx", exp);

    // Write on the same edge as the STOP->START pop with two bytes queued.
    rx_q.delete();
    step(1'b1, 1'b1, 8'h31);
    step(1'b1, 1'b1, 8'h32);
    step(1'b1, 1'b1, 8'h33);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_active && m_elapsed == FRAME - 1) begin found = 1; break; end
      step(1'b1, 1'b0, 8'h00);
    end
    if (!found) fail_now("t5_sync");
    check("t5_count_before", bus.count, 2);
    step(1'b1, 1'b1, 8'h34);
    check("t5_count_kept", bus.count, 2);
    drain("t5_drain", drop_c);
    exp = '{8'h31, 8'h32, 8'h33, 8'h34};
    check_rx("t5_rx", exp);

    // Asynchronous reset during DATA bit 3 with bytes queued.
    rx_q.delete();
    step(1'b1, 1'b1, 8'h41);
    step(1'b1, 1'b1, 8'h42);
    step(1'b1, 1'b1, 8'h43);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_active && m_elapsed == 4 * CPB + CPB / 2) begin found = 1; break; end
      step(1'b1, 1'b0, 8'h00);
    end
    if (!found) fail_now("t6_sync");
    check("t6_tx_low_bit3_pre", bus.tx, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_tx", bus.tx, 1'b1);
    check("t6_async_count", bus.count, 0);
    check("t6_async_empty", bus.empty, 1'b1);
    model_reset();
    step(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b1, 1'b0, 8'h00);
    check("t6_no_frame", rx_q.size(), 0);
    step(1'b1, 1'b1, 8'h5A);
    drain("t6_drain", drop_c);
    exp = '{8'h5A};
    check_rx("t6_rx", exp);

    // Randomized traffic against the model, including overflow pressure.
    rx_q.delete(); m_sent.delete();
    for (int k = 0; k < 3000; k++) begin
      logic we;
      we = ($urandom_range(0, 99) < 4);
      step(1'b1, we, 8'($urandom_range(0, 255)));
    end
    drain("rand_drain", drop_c);
    check_rx("rand_rx", m_sent);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
